// File: rtl/word_byte_serializer.sv
// Two-channel word FIFOs, round-robin arbitration, framed MSB-first byte stream out.
// Optional CHECKSUM_EN appends an XOR byte of the four data bytes to each frame.
module word_byte_serializer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] HEADER_1   = 8'hA1,
    parameter logic [7:0] HEADER_2   = 8'hA2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] word_1,
    input  logic        word_1_valid,
    input  logic [31:0] word_2,
    input  logic        word_2_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        overflow_1,
    output logic        overflow_2,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_B3   = 3'd2;
    localparam logic [2:0] S_B2   = 3'd3;
    localparam logic [2:0] S_B1   = 3'd4;
    localparam logic [2:0] S_B0   = 3'd5;
`ifdef CHECKSUM_EN
    localparam logic [2:0] S_CK   = 3'd6;
`endif

    logic [1:0]         push_v;
    logic [1:0][31:0]   push_w;
    logic [1:0]         pop;
    logic [1:0]         nonempty;
    logic [1:0]         ovf;
    logic [1:0][31:0]   head;

    assign push_v = {word_2_valid, word_1_valid};
    assign push_w = {word_2, word_1};

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [FIFO_DEPTH-1:0][31:0] mem_q;
        logic [AW-1:0]               wp_q, rp_q;
        logic [CW-1:0]               cnt_q;
        logic                        ovf_q;
        logic                        acc;

        // A full FIFO still takes the word when the same edge pops it.
        assign acc = push_v[g] && ((cnt_q < CW'(FIFO_DEPTH)) || pop[g]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                ovf_q <= push_v[g] && !acc;
                if (acc)    wp_q <= wp_q + 1'b1;
                if (pop[g]) rp_q <= rp_q + 1'b1;
                case ({acc, pop[g]})
                    2'b10:   cnt_q <= cnt_q + 1'b1;
                    2'b01:   cnt_q <= cnt_q - 1'b1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (acc) mem_q[wp_q] <= push_w[g];
        end

        assign nonempty[g] = (cnt_q != '0);
        assign ovf[g]      = ovf_q;
        assign head[g]     = mem_q[rp_q];
    end

    logic [2:0]  state_q, state_d;
    logic [31:0] word_q, word_d;
    logic        last2_q, last2_d;   // 1: channel 2 was served last
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        adv;

    always_comb begin
        pop = 2'b00;
        if (state_q == S_IDLE) begin
            if (nonempty == 2'b11) pop = last2_q ? 2'b01 : 2'b10;
            else                   pop = nonempty;
        end
    end

    assign adv = tx_valid_q && tx_ready;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        last2_d    = last2_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        case (state_q)
            S_IDLE: if (|pop) begin
                state_d    = S_HDR;
                word_d     = pop[0] ? head[0] : head[1];
                last2_d    = pop[1];
                tx_valid_d = 1'b1;
                tx_data_d  = pop[1] ? HEADER_2 : HEADER_1;
            end
            S_HDR: if (adv) begin state_d = S_B3; tx_data_d = word_q[31:24]; end
            S_B3:  if (adv) begin state_d = S_B2; tx_data_d = word_q[23:16]; end
            S_B2:  if (adv) begin state_d = S_B1; tx_data_d = word_q[15:8];  end
            S_B1:  if (adv) begin state_d = S_B0; tx_data_d = word_q[7:0];   end
`ifdef CHECKSUM_EN
            S_B0: if (adv) begin
                state_d   = S_CK;
                tx_data_d = word_q[31:24] ^ word_q[23:16] ^ word_q[15:8] ^ word_q[7:0];
            end
            S_CK: if (adv) begin state_d = S_IDLE; tx_valid_d = 1'b0; end
`else
            S_B0: if (adv) begin state_d = S_IDLE; tx_valid_d = 1'b0; end
`endif
            default: begin state_d = S_IDLE; tx_valid_d = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            last2_q    <= 1'b1;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            last2_q    <= last2_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign overflow_1 = ovf[0];
    assign overflow_2 = ovf[1];
    assign busy       = (state_q != S_IDLE) || (|nonempty);
endmodule

// File: tb/tb_word_byte_serializer.sv
// Directed + random bench for word_byte_serializer against a queue-based frame model.
module tb_word_byte_serializer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] word_1 = '0, word_2 = '0;
    logic        word_1_valid = 1'b0, word_2_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid, overflow_1, overflow_2, busy;

    word_byte_serializer #(.FIFO_DEPTH(DEPTH), .HEADER_1(8'hA1), .HEADER_2(8'hA2)) dut (
        .clk(clk), .rst(rst),
        .word_1(word_1), .word_1_valid(word_1_valid),
        .word_2(word_2), .word_2_valid(word_2_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .overflow_1(overflow_1), .overflow_2(overflow_2), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: per-channel word queues, the byte list of the frame in flight.
    logic [31:0] q1[$], q2[$];
    logic [7:0]  fb[$];
    bit          m_active = 0;
    int          last = 2;
    bit          e_ovf1 = 0, e_ovf2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void start_frame(input int ch, input logic [31:0] w);
        fb.delete();
        fb.push_back(ch == 1 ? 8'hA1 : 8'hA2);
        for (int i = 3; i >= 0; i--) fb.push_back(w[8*i +: 8]);
`ifdef CHECKSUM_EN
        fb.push_back(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
        m_active = 1;
        last = ch;
    endfunction

    function automatic bit m_busy();
        return m_active || (q1.size() != 0) || (q2.size() != 0);
    endfunction

    task automatic set_push(input int ch, input logic [31:0] w);
        if (ch == 1) begin word_1 = w; word_1_valid = 1'b1; end
        else         begin word_2 = w; word_2_valid = 1'b1; end
    endtask

    // One clock: check the byte on offer, advance the model, clock, check outputs.
    task automatic cyc();
        if (m_active) chk("tx_data", {24'h0, tx_data}, {24'h0, fb[0]});
        e_ovf1 = 0;
        e_ovf2 = 0;
        if (m_active) begin
            if (tx_ready) begin
                void'(fb.pop_front());
                if (fb.size() == 0) m_active = 0;
            end
        end else if (q1.size() != 0 && q2.size() != 0) begin
            if (last == 2) start_frame(1, q1.pop_front());
            else           start_frame(2, q2.pop_front());
        end else if (q1.size() != 0) start_frame(1, q1.pop_front());
        else if (q2.size() != 0)     start_frame(2, q2.pop_front());
        if (word_1_valid) begin
            if (q1.size() < DEPTH) q1.push_back(word_1); else e_ovf1 = 1;
        end
        if (word_2_valid) begin
            if (q2.size() < DEPTH) q2.push_back(word_2); else e_ovf2 = 1;
        end
        @(posedge clk);
        #1;
        word_1_valid = 1'b0;
        word_2_valid = 1'b0;
        chk("tx_valid",   tx_valid,   m_active);
        chk("busy",       busy,       m_busy());
        chk("overflow_1", overflow_1, e_ovf1);
        chk("overflow_2", overflow_2, e_ovf2);
    endtask

    task automatic drain();
        tx_ready = 1'b1;
        for (int i = 0; i < 200 && m_busy(); i++) cyc();
        chk("drain_busy", busy, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_busy",     busy,     1'b0);
        chk("rst_tx_data",  {24'h0, tx_data}, 32'h0);
        chk("rst_ovf",      {overflow_2, overflow_1}, 2'b00);
        q1.delete(); q2.delete(); fb.delete();
        m_active = 0; last = 2; e_ovf1 = 0; e_ovf2 = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // T1 single word; header must be on offer right after the pop edge
        tx_ready = 1'b1;
        set_push(1, 32'h11223344);
        cyc();
        chk("t1_no_hdr_yet", tx_valid, 1'b0);
        cyc();
        chk("t1_hdr", {24'h0, tx_data}, 32'hA1);
        drain();

        // T2 backpressure, ready pattern 1,0,0,1,...
        set_push(1, 32'h11223344);
        for (int i = 0; i < 24; i++) begin
            tx_ready = (i % 3 == 0);
            cyc();
        end
        drain();

        // T3 fairness: C alone first, then A+D, then B -> C,A,D,B
        tx_ready = 1'b0;
        set_push(2, 32'hCCCC0001); cyc();
        set_push(1, 32'hAAAA0001); set_push(2, 32'hDDDD0001); cyc();
        set_push(1, 32'hBBBB0001); cyc();
        drain();

        // T4 overflow on ch1 while stalled, ch2 untouched
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_push(1, $urandom);
            cyc();
        end
        drain();

        // T6 full FIFO, keep pushing while frames drain so a push meets a pop
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin set_push(1, $urandom); cyc(); end
        tx_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin set_push(1, $urandom); cyc(); end
        drain();

        // T5 reset after byte 22, then a clean frame
        tx_ready = 1'b1;
        set_push(1, 32'h11223344);
        repeat (5) cyc();
        do_reset();
        set_push(1, 32'hDEADBEEF);
        cyc();
        cyc();
        chk("t5_hdr", {24'h0, tx_data}, 32'hA1);
        drain();

        // Random traffic and backpressure
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) set_push(1, $urandom);
            if ($urandom_range(3) == 0) set_push(2, $urandom);
            tx_ready = ($urandom_range(3) != 0);
            cyc();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
